// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter feeding an external 8-stage 4-bit shift line.
// Shadow valid/tag registers track the line so output strobes and sources are known.
module shift_arb_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [3:0] a_data,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [3:0] b_data,
    output logic       b_ready,
    input  logic       flush,
    output logic       shn,
    output logic [3:0] si,
    input  logic [3:0] so,
    output logic       out_valid,
    output logic [3:0] out_data,
    output logic       out_src,
    output logic       busy,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 4;
    localparam int unsigned OCC_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DEPTH-1:0]   v;
    logic [DEPTH-1:0]   t;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_nxt;
    logic               ptr_b;
    logic               grant_a;
    logic               grant_b;
    logic               accept;
    logic               shift;
    logic               blocked;
    logic [DW-1:0]      si_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, shift control and next state; flush in RUN takes precedence over requests
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        accept    = 1'b0;
        shift     = 1'b0;
        si_c      = '0;
        occ_nxt   = occ;
        blocked   = rst || (state == DRAIN) || ((state == RUN) && flush);

        if (!blocked) begin
            if (a_valid && b_valid) begin
                grant_b = ptr_b;
                grant_a = !ptr_b;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end

        accept = grant_a || grant_b;
        shift  = !rst && (accept || (state == DRAIN));

        if (grant_b) begin
            si_c = b_data;
        end else if (grant_a) begin
            si_c = a_data;
        end

        if (shift) begin
            occ_nxt = occ + OCC_W'(accept) - OCC_W'(v[DEPTH-1]);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (occ_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (occ_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow line, occupancy, priority pointer and output strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v         <= '0;
            t         <= '0;
            occ       <= '0;
            ptr_b     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= shift && v[DEPTH-2];
            busy      <= (state_nxt != IDLE);
            if (shift) begin
                v   <= {v[DEPTH-2:0], accept};
                t   <= {t[DEPTH-2:0], grant_b};
                occ <= occ_nxt;
            end
            if (accept) begin
                ptr_b <= grant_a;
            end
        end
    end

    // Saturating per-requester accept counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (grant_a && (cnt_a != '1)) begin
                cnt_a <= cnt_a + 8'd1;
            end
            if (grant_b && (cnt_b != '1)) begin
                cnt_b <= cnt_b + 8'd1;
            end
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign shn      = shift;
    assign si       = si_c;
    assign out_src  = t[DEPTH-1];
    assign out_data = so;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: vector table, directed corner sequences and random traffic
// checked against a timestamp-based model of the arbiter and shift line.
module tb_shift_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, b_valid, flush;
    logic [3:0] a_data, b_data;
    logic       a_ready, b_ready, shn, out_valid, out_src, busy;
    logic [3:0] si, so, out_data;
    logic [7:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    shift_arb_ctrl dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .flush(flush), .shn(shn), .si(si), .so(so),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // External shift line driven by the DUT
    logic [3:0] line [8];
    assign so = line[7];
    initial for (int i = 0; i < 8; i++) line[i] = 4'd0;
    always @(posedge clk) begin
        if (shn) begin
            for (int i = 7; i > 0; i--) line[i] <= line[i-1];
            line[0] <= si;
        end
    end

    // Reference model: each accepted word carries the index of the shift that took it;
    // it is presented after shift k+7 and leaves the line on shift k+8.
    typedef struct {
        logic [3:0] d;
        bit         src;
        int         k;
    } word_t;

    word_t      live[$];
    int         nshift = 0;
    bit         drain;
    bit         a_prio;
    int         ca, cb;
    bit         m_ga, m_gb, m_shn;
    logic [3:0] m_si;
    bit         exp_ov;
    logic [3:0] exp_od;
    bit         exp_os;

    logic       s_a_ready, s_b_ready, s_shn;
    logic [3:0] s_si;
    int         cyc = 0;
    logic [3:0] seen_d[$];
    bit         seen_s[$];
    int         seen_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        live.delete();
        drain  = 1'b0;
        a_prio = 1'b1;
        ca     = 0;
        cb     = 0;
        exp_ov = 1'b0;
    endtask

    task automatic model_comb();
        bit busy_m;
        busy_m = (live.size() != 0);
        m_ga = 1'b0;
        m_gb = 1'b0;
        if (!(drain || (busy_m && flush))) begin
            if (a_valid && b_valid) begin
                m_ga = a_prio;
                m_gb = !a_prio;
            end else begin
                m_ga = a_valid;
                m_gb = b_valid;
            end
        end
        m_shn = m_ga || m_gb || drain;
        m_si  = m_gb ? b_data : a_data;
    endtask

    task automatic model_edge();
        word_t w;
        bit    was_busy;
        was_busy = (live.size() != 0);
        exp_ov   = 1'b0;
        if (m_shn) begin
            if (live.size() > 0 && live[0].k + 8 == nshift) void'(live.pop_front());
            if (live.size() > 0 && live[0].k + 7 == nshift) begin
                exp_ov = 1'b1;
                exp_od = live[0].d;
                exp_os = live[0].src;
            end
            if (m_ga || m_gb) begin
                w.d = m_si; w.src = m_gb; w.k = nshift;
                live.push_back(w);
            end
            nshift++;
        end
        if (m_ga) ca = (ca < 255) ? ca + 1 : 255;
        if (m_gb) cb = (cb < 255) ? cb + 1 : 255;
        if (m_ga || m_gb) a_prio = m_gb;
        if (was_busy && !drain && flush) drain = 1'b1;
        if (live.size() == 0) drain = 1'b0;
    endtask

    // One clock: drive at negedge, check combinational outputs, then registered ones after the edge
    task automatic step(input bit av, input logic [3:0] ad, input bit bv,
                        input logic [3:0] bd, input bit fl);
        @(negedge clk);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; flush = fl;
        model_comb();
        #1;
        s_a_ready = a_ready; s_b_ready = b_ready; s_shn = shn; s_si = si;
        chk("a_ready", a_ready, m_ga);
        chk("b_ready", b_ready, m_gb);
        chk("shn", shn, m_shn);
        if (m_ga || m_gb) chk("si", si, m_si);
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_data", out_data, exp_od);
            chk("out_src", out_src, exp_os);
        end
        chk("busy", busy, live.size() != 0);
        chk("cnt_a", cnt_a, ca);
        chk("cnt_b", cnt_b, cb);
        if (out_valid) begin
            seen_d.push_back(out_data);
            seen_s.push_back(out_src);
            seen_c.push_back(cyc);
        end
        cyc++;
    endtask

    // Asynchronous reset between edges; released just after a rising edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        a_valid = 1'b1; a_data = 4'd7; b_valid = 1'b0; b_data = 4'd0; flush = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_shn", shn, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_a", cnt_a, 0);
        chk("rst_cnt_b", cnt_b, 0);
        repeat (2) @(posedge clk);
        #2;
        a_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    typedef struct {
        bit         av;
        logic [3:0] ad;
        bit         bv;
        logic [3:0] bd;
        bit         fl;
        bit         ea;
        bit         eb;
        bit         eshn;
        logic [3:0] esi;
        bit         ebusy;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; a_data = 4'd0; b_data = 4'd0;
        model_reset();

        // av ad bv bd fl | a_ready b_ready shn si busy_after
        tbl[0] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        tbl[1] = '{1'b1, 4'd3, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1};
        tbl[2] = '{1'b1, 4'd4, 1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b1};
        tbl[3] = '{1'b1, 4'd5, 1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1};
        tbl[4] = '{1'b0, 4'd0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        tbl[5] = '{1'b0, 4'd0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1};
        tbl[6] = '{1'b1, 4'd6, 1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
        tbl[7] = '{1'b1, 4'd8, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1};

        do_reset();
        for (int r = 0; r < 8; r++) begin
            step(tbl[r].av, tbl[r].ad, tbl[r].bv, tbl[r].bd, tbl[r].fl);
            chk("tbl_a_ready", s_a_ready, tbl[r].ea);
            chk("tbl_b_ready", s_b_ready, tbl[r].eb);
            chk("tbl_shn", s_shn, tbl[r].eshn);
            if (tbl[r].eshn) chk("tbl_si", s_si, tbl[r].esi);
            chk("tbl_busy", busy, tbl[r].ebusy);
        end
        idle(12);
        chk("tbl_drained", busy, 0);

        // A streams 1..9: first strobe right after the 8th accept
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 4'(i), 1'b0, 4'd0, 1'b0);
            chk("s1_ov", out_valid, i >= 8);
            if (i >= 8) begin
                chk("s1_data", out_data, i - 7);
                chk("s1_src", out_src, 0);
            end
        end
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(10);

        // A and B together: grants alternate starting with A
        do_reset();
        seen_s.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(i), 1'b1, 4'(8 + i), 1'b0);
            chk("s2_a_ready", s_a_ready, (i % 2) == 0);
            chk("s2_b_ready", s_b_ready, (i % 2) == 1);
        end
        chk("s2_cnt_a", cnt_a, 2);
        chk("s2_cnt_b", cnt_b, 2);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(10);
        chk("s2_nout", seen_s.size(), 4);
        for (int i = 0; i < seen_s.size() && i < 4; i++) chk("s2_src_seq", seen_s[i], i % 2);

        // Three words then flush: ready held low, words emerge back to back
        do_reset();
        seen_d.delete();
        seen_c.delete();
        step(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd8, 1'b0, 4'd0, 1'b1);
        chk("s3_flush_ready", s_a_ready, 0);
        for (int i = 1; i <= 12; i++) begin
            step(i <= 5, 4'd9, 1'b0, 4'd0, 1'b0);
            if (i <= 5) chk("s3_drain_ready", s_a_ready, 0);
            chk("s3_busy", busy, i < 8);
        end
        chk("s3_nout", seen_d.size(), 3);
        for (int i = 0; i < seen_d.size() && i < 3; i++) begin
            chk("s3_data", seen_d[i], 5 + i);
            chk("s3_consec", seen_c[i] - seen_c[0], i);
        end

        // Single word parks in stage 0 with no further traffic
        do_reset();
        step(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            chk("s4_shn", s_shn, 0);
            chk("s4_ov", out_valid, 0);
            chk("s4_busy", busy, 1);
        end
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(10);
        chk("s4_drained", busy, 0);

        // Reset in the middle of a drain, then counter saturation
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 4'(i + 2), 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(3);
        do_reset();
        seen_d.delete();
        idle(12);
        chk("s6_no_out", seen_d.size(), 0);
        for (int i = 0; i < 300; i++) step(1'b1, 4'($urandom), 1'b0, 4'd0, 1'b0);
        chk("s6_cnt_a_sat", cnt_a, 255);
        step(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        idle(10);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) == 0,
                     4'($urandom), $urandom_range(0, 15) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
